// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter_pkg
//  Description : Shared grid geometry and requester identities for the grid
//                RAM port arbiter and the blocks around it.
//  Contents    : GRID_DEPTH/GRID_W/GRID_H geometry constants and the port_e
//                requester enumeration (PORT_COMPUTE=0, PORT_HOST=1).
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_port_arbiter_pkg;

    localparam int GRID_W     = 50;
    localparam int GRID_H     = 50;
    localparam int GRID_DEPTH = GRID_W * GRID_H;   // 2500 legal words

    // Requester identity; the value doubles as the port index.
    typedef enum logic {
        PORT_COMPUTE = 1'b0,
        PORT_HOST    = 1'b1
    } port_e;

endpackage : ram_port_arbiter_pkg
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares one single-port grid RAM (1-cycle read latency)
//                between the CFD compute engine (port 0) and the host
//                load/unload path (port 1). Round-robin grant with an
//                optional burst lock, valid/ready request handshake and one
//                response pulse per accepted access.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                reqN_valid/ready       - request handshake (N = 0, 1)
//                reqN_we/lock/addr/wdata- request attributes
//                rspN_valid/rdata/err   - response one cycle after acceptance
//                ram_addr/data_in/write_en/data_out - grid RAM interface
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = GRID_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_we,
    input  logic                     req0_lock,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    output logic                     rsp0_valid,
    output logic [DATA_WIDTH-1:0]    rsp0_rdata,
    output logic                     rsp0_err,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_we,
    input  logic                     req1_lock,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp1_rdata,
    output logic                     rsp1_err,

    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    output logic                     ram_write_en,
    input  logic [DATA_WIDTH-1:0]    ram_data_out
);

    // Arbitration state
    port_e prio_q, prio_d;              // port that wins a tie
    logic  lock_vld_q, lock_vld_d;      // a lock owner exists
    port_e lock_port_q, lock_port_d;    // which port owns the lock

    // Response pipeline (describes the access accepted last cycle)
    logic  rsp_pending_q, rsp_pending_d;
    port_e rsp_port_q, rsp_port_d;
    logic  rsp_err_q, rsp_err_d;

    logic [1:0]               w_valid;
    logic                     w_grant_vld;
    port_e                    w_grant_port;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_wdata;
    logic                     w_sel_we;
    logic                     w_sel_lock;
    logic                     w_in_range;
    logic                     w_ram_go;
    logic                     w_rsp_live;

    assign w_valid = {req1_valid, req0_valid};

    // Grant: a live lock owner wins outright, a lone requester wins, and a
    // tie goes to the priority pointer.
    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_port = prio_q;
        if (lock_vld_q && w_valid[lock_port_q]) begin
            w_grant_vld  = 1'b1;
            w_grant_port = lock_port_q;
        end else if (req0_valid && !req1_valid) begin
            w_grant_vld  = 1'b1;
            w_grant_port = PORT_COMPUTE;
        end else if (req1_valid && !req0_valid) begin
            w_grant_vld  = 1'b1;
            w_grant_port = PORT_HOST;
        end else if (req0_valid && req1_valid) begin
            w_grant_vld  = 1'b1;
            w_grant_port = prio_q;
        end
    end

    assign req0_ready = w_grant_vld && (w_grant_port == PORT_COMPUTE);
    assign req1_ready = w_grant_vld && (w_grant_port == PORT_HOST);

    assign w_sel_addr  = (w_grant_port == PORT_HOST) ? req1_addr  : req0_addr;
    assign w_sel_wdata = (w_grant_port == PORT_HOST) ? req1_wdata : req0_wdata;
    assign w_sel_we    = (w_grant_port == PORT_HOST) ? req1_we    : req0_we;
    assign w_sel_lock  = (w_grant_port == PORT_HOST) ? req1_lock  : req0_lock;
    assign w_in_range  = (int'(w_sel_addr) < DEPTH);

    // Out-of-range or idle cycles park the RAM on a harmless read of word 0.
    assign w_ram_go     = w_grant_vld && w_in_range;
    assign ram_addr     = w_ram_go ? w_sel_addr  : '0;
    assign ram_data_in  = w_ram_go ? w_sel_wdata : '0;
    assign ram_write_en = w_ram_go && w_sel_we;

    always_comb begin
        prio_d        = prio_q;
        lock_vld_d    = lock_vld_q;
        lock_port_d   = lock_port_q;
        rsp_pending_d = w_grant_vld;
        rsp_port_d    = w_grant_port;
        rsp_err_d     = w_grant_vld && !w_in_range;
        if (w_grant_vld) begin
            prio_d      = (w_grant_port == PORT_COMPUTE) ? PORT_HOST : PORT_COMPUTE;
            lock_vld_d  = w_sel_lock;
            lock_port_d = w_grant_port;
        end else if (lock_vld_q && !w_valid[lock_port_q]) begin
            // Owner went idle: release so the other port is not starved.
            lock_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q        <= PORT_COMPUTE;
            lock_vld_q    <= 1'b0;
            lock_port_q   <= PORT_COMPUTE;
            rsp_pending_q <= 1'b0;
            rsp_port_q    <= PORT_COMPUTE;
            rsp_err_q     <= 1'b0;
        end else begin
            prio_q        <= prio_d;
            lock_vld_q    <= lock_vld_d;
            lock_port_q   <= lock_port_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_port_q    <= rsp_port_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // The RAM output register already holds the access result in the
    // response cycle, so the data path is steered from it directly. Reset
    // suppresses a response whose access was accepted just before reset.
    assign w_rsp_live = rsp_pending_q && !rst;
    assign rsp0_valid = w_rsp_live && (rsp_port_q == PORT_COMPUTE);
    assign rsp1_valid = w_rsp_live && (rsp_port_q == PORT_HOST);
    assign rsp0_err   = rsp0_valid && rsp_err_q;
    assign rsp1_err   = rsp1_valid && rsp_err_q;
    assign rsp0_rdata = (rsp0_valid && !rsp_err_q) ? ram_data_out : '0;
    assign rsp1_rdata = (rsp1_valid && !rsp_err_q) ? ram_data_out : '0;

endmodule : ram_port_arbiter
`default_nettype wire
